// File: rtl/mem_init_pkg.sv
// ============================================================================
// Module   : mem_init_pkg
// Purpose  : Shared types for the memory initialisation sequencer: the
//            sequencer state encoding, the fill-pattern selector and a helper
//            that maps the raw 2-bit mode input onto the pattern selector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_init_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      VRFY   = 3'd2,
      VDRAIN = 3'd3,
      DONE   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      IDENTITY = 2'd0,
      CONST    = 2'd1,
      DESCEND  = 2'd2
   } mode_e;

   // The reserved encoding 3 folds onto IDENTITY so the latched mode is
   // always one of the three real patterns.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      mode_e m;
      case (raw)
         2'd1:    m = CONST;
         2'd2:    m = DESCEND;
         default: m = IDENTITY;
      endcase
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_init_pattern.sv
// ============================================================================
// Module   : mem_init_pattern
// Purpose  : Combinational fill-pattern generator. Used both for the write
//            data and for the expected value during readback.
// Ports    : mode       - latched pattern selector
//            fill_value - latched constant for CONST
//            index      - word index being written / checked
//            data       - pattern value for that index
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_init_pattern
   import mem_init_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  mode_e              mode,
   input  logic [DATA_W-1:0]  fill_value,
   input  logic [ADDR_W-1:0]  index,
   output logic [DATA_W-1:0]  data
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] w_desc;
   logic [ADDR_W-1:0] w_seq;
   logic [DATA_W-1:0] w_seq_ext;

   // index never exceeds DEPTH-1, so this subtraction cannot wrap.
   assign w_desc = LAST - index;
   assign w_seq  = (mode == DESCEND) ? w_desc : index;

   // Fit the address-wide sequence value into the data width.
   generate
      if (DATA_W > ADDR_W) begin : g_zext
         assign w_seq_ext = {{(DATA_W-ADDR_W){1'b0}}, w_seq};
      end else if (DATA_W < ADDR_W) begin : g_trunc
         assign w_seq_ext = w_seq[DATA_W-1:0];
      end else begin : g_same
         assign w_seq_ext = w_seq;
      end
   endgenerate

   assign data = (mode == CONST) ? fill_value : w_seq_ext;

endmodule

`default_nettype wire

// File: rtl/mem_init_seq.sv
// ============================================================================
// Module   : mem_init_seq
// Purpose  : Fills DEPTH words of a single-port RAM with a selectable pattern,
//            one write per clock, and optionally reads the words back to
//            check them. Build option MEM_INIT_VERIFY_EN enables readback
//            verify; without it verify_err is tied low.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            start, abort        - begin a fill / cancel a running one
//            mode, fill_value    - pattern select and constant (latched)
//            address, data, wren - RAM write/read port
//            q                   - RAM read data (one cycle after address)
//            busy, done          - status levels
//            verify_err          - sticky readback mismatch flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_init_seq
   import mem_init_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] fill_value,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   input  logic [DATA_W-1:0] q,
   output logic              busy,
   output logic              done,
   output logic              verify_err
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

`ifdef MEM_INIT_VERIFY_EN
   localparam state_e FILL_EXIT = VRFY;
`else
   localparam state_e FILL_EXIT = DONE;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d;
   mode_e             mode_q,  mode_d;
   logic [DATA_W-1:0] fill_q,  fill_d;
   logic [DATA_W-1:0] w_pat;
   logic              w_err_clr;

   mem_init_pattern #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_pattern (
      .mode       (mode_q),
      .fill_value (fill_q),
      .index      (index_q),
      .data       (w_pat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         index_q <= '0;
         mode_q  <= IDENTITY;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         mode_q  <= mode_d;
         fill_q  <= fill_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      mode_d    = mode_q;
      fill_d    = fill_q;
      w_err_clr = 1'b0;
      address   = '0;
      data      = '0;
      wren      = 1'b0;
      busy      = (state_q != IDLE) && (state_q != DONE);
      done      = (state_q == DONE);

      case (state_q)
         IDLE, DONE: begin
            if (start && !abort) begin
               state_d   = WRITE;
               index_d   = '0;
               mode_d    = decode_mode(mode);
               fill_d    = fill_value;
               w_err_clr = 1'b1;
            end
         end

         WRITE: begin
            wren    = 1'b1;
            address = index_q;
            data    = w_pat;
            if (abort) begin
               state_d = IDLE;
               index_d = '0;
            end else if (index_q == LAST) begin
               state_d = FILL_EXIT;
               index_d = '0;
            end else begin
               index_d = index_q + ADDR_W'(1);
            end
         end

         // Readback sweep: the word addressed here is compared next cycle.
         VRFY: begin
            address = index_q;
            if (abort) begin
               state_d = IDLE;
               index_d = '0;
            end else if (index_q == LAST) begin
               state_d = VDRAIN;
               index_d = '0;
            end else begin
               index_d = index_q + ADDR_W'(1);
            end
         end

         // One extra cycle to compare the last word read in VRFY.
         VDRAIN: begin
            state_d = abort ? IDLE : DONE;
         end

         default: begin
            state_d = IDLE;
            index_d = '0;
         end
      endcase
   end

`ifdef MEM_INIT_VERIFY_EN
   logic [DATA_W-1:0] exp_q;
   logic              cmp_vld_q;
   logic              err_q;

   // exp_q tracks the pattern of the address presented last cycle, lining
   // it up with the RAM's one-cycle read latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         exp_q     <= '0;
         cmp_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         exp_q     <= w_pat;
         cmp_vld_q <= (state_q == VRFY) && !abort;
         if (w_err_clr) begin
            err_q <= 1'b0;
         end else if (cmp_vld_q && !abort && (q != exp_q)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign verify_err = err_q;
`else
   logic unused_q;
   assign unused_q   = ^q;
   assign verify_err = 1'b0;
`endif

endmodule

`default_nettype wire
